multi_channel_summing_accumulator: RTL
======================================

Name: multi_channel_summing_accumulator

Overview:
- Parametrised successor to the single-stream order-independent summing tree.
- Accepts a serial stream of beats, each tagged with a channel ID. Keeps one independent running sum per channel, with a runtime-programmable beat count per transaction and selectable signed/unsigned arithmetic.
- A completed channel sum is presented on one shared output port with a valid/ready handshake, arbitrated round-robin across channels.
- Sits between per-channel sample producers and a single downstream consumer.

Parameters:
- NUM_CHANNELS, 4: number of independent accumulation channels (>=1).
- DATA_WIDTH, 8: width of each input beat.
- MAX_INPUTS, 16: maximum beats per transaction (>=1).
- SIGNED_MODE, 0: 0 = unsigned two's-complement-free sum; 1 = signed, with data_in sign-extended.
- Derived CH_W = max(1,$clog2(NUM_CHANNELS)); CNT_W = $clog2(MAX_INPUTS+1); SUM_W = DATA_WIDTH + $clog2(MAX_INPUTS).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  input beat valid.
- ch_in  in  CH_W  channel ID of the beat.
- data_in  in  DATA_WIDTH  beat value.
- cfg_count  in  CNT_W  beats in a transaction; sampled per channel on its first beat.
- ready_out  out  NUM_CHANNELS  per-channel accept-ready.
- sum_valid  out  1  output sum valid.
- sum_ready  in  1  downstream accept.
- sum_out  out  SUM_W  completed sum (signed when SIGNED_MODE=1).
- sum_channel  out  CH_W  channel that produced sum_out.
- sum_count  out  CNT_W  number of beats summed.

Behaviour:

Reset:
- While rst=1 at a clock edge, every channel goes to IDLE, with accumulators and beat counters cleared.
- sum_valid=0; sum_out, sum_channel and sum_count = 0; round-robin pointer = 0.
- ready_out = all ones from the first cycle after reset.
- Reset mid-transaction discards all partial sums and any pending or undelivered output.

Per-channel FSM (IDLE, ACCUM, DONE):
- ready_out[c] = (state[c] != DONE), driven from registered state only.
- A beat is accepted iff valid_in && ch_in < NUM_CHANNELS && ready_out[ch_in]. Non-accepted beats are dropped with no side effect.
- IDLE, on accept:
  - Latch target = cfg_count. A value of 0 or greater than MAX_INPUTS is clamped to MAX_INPUTS.
  - acc = ext(data_in); cnt = 1.
  - Go to DONE if target==1, else to ACCUM.
- ACCUM, on accept: acc += ext(data_in); cnt += 1. When cnt reaches target, go to DONE.
- DONE: holds acc and cnt until granted by the output stage. It then returns to IDLE with acc and cnt cleared, and ready_out[c] rises the following cycle.
- ext() is zero-extension when SIGNED_MODE=0 and sign-extension when SIGNED_MODE=1, to SUM_W bits.
- No overflow is possible for any legal count.

Output stage (registered, one entry):
- Load is enabled when !sum_valid || sum_ready.
- When enabled, the arbiter grants the first DONE channel at or after rr_ptr, searching upward with wrap.
- The granted channel's acc, ID and cnt load into sum_out, sum_channel and sum_count; sum_valid is set.
- rr_ptr is updated to (granted+1) mod NUM_CHANNELS.
- If load is enabled and no channel is DONE, sum_valid clears.
- Latency: last beat accepted at edge E -> channel DONE after E -> sum_valid=1 after edge E+1, provided the output register is free or draining at E+1.
- While sum_valid && !sum_ready, sum_out, sum_channel and sum_count are held stable.
- A transfer occurs on sum_valid && sum_ready. Back-to-back transfers at one per cycle are supported when several channels are DONE.

Concurrency:
- Accepts on channel a and a grant of channel b are independent within the same cycle.
- A channel cannot receive beats while in DONE, so no beat is lost to a pending sum.
- Beat order within and across channels does not affect any sum.

Test Plan:
1. Single channel, unsigned: cfg_count=8; ch0 receives 10,20,…,80 with random 1–3 cycle gaps; sum_ready=1 -> sum_out=360, sum_channel=0, sum_count=8, sum_valid high exactly one edge after the 8th beat is accepted, then low.
2. Interleaved channels: ch1 cfg_count=4 receives 255×4; ch2 cfg_count=2 receives 1,2, interleaved so that ch2 finishes first -> first output {ch2, 3, count 2}, then {ch1, 1020, count 4}.
3. Backpressure and round-robin: ch0 and ch3 (cfg_count=1) complete in the same cycle with sum_ready=0.
   - Output {ch0} is held stable for 5 cycles.
   - ready_out[3]=0, and a beat sent to ch3 is dropped.
   - On release of sum_ready, outputs are ch0 then ch3 in consecutive cycles.
   - A repeat completion on ch0 and ch3 is then granted ch0 first again (rr_ptr=0 after the ch3 grant).
4. Signed mode (SIGNED_MODE=1): −128×16 with cfg_count=16 -> sum_out=−2048 (12'h800); the beats 100, −50 with cfg_count=2 -> 50.
5. Width and clamp (unsigned): 255×16 with cfg_count=0 -> clamped to 16, sum_out=4080, sum_count=16; cfg_count=20 also clamps to 16.
6. Reset mid-transaction: ch0 accepts 3 of 8 beats; rst is pulsed for 1 cycle.
   - Immediately after: sum_valid=0, all outputs 0, ready_out=4'b1111.
   - A fresh 8-beat ch0 transaction of 1..8 -> sum_out=36, with no pre-reset contribution.

Source files
------------

// File: rtl/multi_channel_summing_accumulator_if.sv
// Beat-input and sum-output bus of multi_channel_summing_accumulator.
// The accumulator uses the slave modport; the producer/consumer side uses master.
interface multi_channel_summing_accumulator_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_INPUTS   = 16
);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_W = $clog2(MAX_INPUTS + 1);
  localparam int SUM_W = DATA_WIDTH + $clog2(MAX_INPUTS);

  logic                    valid_in;
  logic [CH_W-1:0]         ch_in;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [CNT_W-1:0]        cfg_count;
  logic [NUM_CHANNELS-1:0] ready_out;
  logic                    sum_valid;
  logic                    sum_ready;
  logic [SUM_W-1:0]        sum_out;
  logic [CH_W-1:0]         sum_channel;
  logic [CNT_W-1:0]        sum_count;

  modport slave (
    input  valid_in, ch_in, data_in, cfg_count, sum_ready,
    output ready_out, sum_valid, sum_out, sum_channel, sum_count
  );

  modport master (
    output valid_in, ch_in, data_in, cfg_count, sum_ready,
    input  ready_out, sum_valid, sum_out, sum_channel, sum_count
  );
endinterface

// File: rtl/multi_channel_summing_accumulator.sv
// Per-channel running sums over a tagged beat stream; completed sums leave through
// one registered valid/ready output stage arbitrated round-robin across channels.
module multi_channel_summing_accumulator #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_INPUTS   = 16,
  parameter int SIGNED_MODE  = 0
) (
  input logic clk,
  input logic rst,
  multi_channel_summing_accumulator_if.slave bus
);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_W = $clog2(MAX_INPUTS + 1);
  localparam int SUM_W = DATA_WIDTH + $clog2(MAX_INPUTS);
  localparam int PAD_N = 2 ** CH_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_r   [NUM_CHANNELS];
  state_e           state_n_s [NUM_CHANNELS];
  logic [SUM_W-1:0] acc_r     [NUM_CHANNELS];
  logic [SUM_W-1:0] acc_n_s   [NUM_CHANNELS];
  logic [CNT_W-1:0] cnt_r     [NUM_CHANNELS];
  logic [CNT_W-1:0] cnt_n_s   [NUM_CHANNELS];
  logic [CNT_W-1:0] tgt_r     [NUM_CHANNELS];
  logic [CNT_W-1:0] tgt_n_s   [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] ready_s;
  logic [NUM_CHANNELS-1:0] hit_s;
  logic [PAD_N-1:0]        ready_pad_s;
  logic [PAD_N-1:0]        done_pad_s;
  logic                    accept_s;
  logic [CNT_W-1:0]        cfg_clamped_s;
  logic [SUM_W-1:0]        beat_ext_s;

  logic                    load_en_s;
  logic                    grant_found_s;
  logic                    grant_s;
  logic [CH_W-1:0]         grant_idx_s;
  logic [CH_W-1:0]         rr_ptr_r;

  logic                    sum_valid_r;
  logic [SUM_W-1:0]        sum_out_r;
  logic [CH_W-1:0]         sum_channel_r;
  logic [CNT_W-1:0]        sum_count_r;

  function automatic logic [SUM_W-1:0] ext_f(input logic [DATA_WIDTH-1:0] d);
    if (SIGNED_MODE != 0) begin
      ext_f = SUM_W'($signed(d));
    end else begin
      ext_f = SUM_W'(d);
    end
  endfunction

  // Accept decode: padded vectors give nonexistent channel IDs a zero ready bit,
  // so beats tagged with them are dropped.
  always_comb begin
    ready_pad_s = {PAD_N{1'b0}};
    done_pad_s  = {PAD_N{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ready_s[c]     = (state_r[c] != ST_DONE);
      ready_pad_s[c] = ready_s[c];
      done_pad_s[c]  = (state_r[c] == ST_DONE);
    end
    accept_s = bus.valid_in && ready_pad_s[bus.ch_in];
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      hit_s[c] = accept_s && (bus.ch_in == CH_W'(c));
    end
    if ((bus.cfg_count == {CNT_W{1'b0}}) || (bus.cfg_count > CNT_W'(MAX_INPUTS))) begin
      cfg_clamped_s = CNT_W'(MAX_INPUTS);
    end else begin
      cfg_clamped_s = bus.cfg_count;
    end
    beat_ext_s = ext_f(bus.data_in);
  end

  // Round-robin arbiter: first DONE channel at or after rr_ptr_r, wrapping upward.
  always_comb begin : arb_comb
    int              idx_v;
    logic [CH_W-1:0] cand_v;
    grant_found_s = 1'b0;
    grant_idx_s   = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx_v = int'(rr_ptr_r) + k;
      if (idx_v >= NUM_CHANNELS) begin
        idx_v = idx_v - NUM_CHANNELS;
      end else begin
        idx_v = idx_v;
      end
      cand_v = idx_v[CH_W-1:0];
      if (!grant_found_s && done_pad_s[cand_v]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_v;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    load_en_s = !sum_valid_r || bus.sum_ready;
    grant_s   = load_en_s && grant_found_s;
  end

  // Per-channel IDLE/ACCUM/DONE next-state and datapath.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_n_s[c] = state_r[c];
      acc_n_s[c]   = acc_r[c];
      cnt_n_s[c]   = cnt_r[c];
      tgt_n_s[c]   = tgt_r[c];
      case (state_r[c])
        ST_IDLE: begin
          if (hit_s[c]) begin
            tgt_n_s[c]   = cfg_clamped_s;
            acc_n_s[c]   = beat_ext_s;
            cnt_n_s[c]   = CNT_W'(1);
            state_n_s[c] = (cfg_clamped_s == CNT_W'(1)) ? ST_DONE : ST_ACCUM;
          end else begin
            state_n_s[c] = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (hit_s[c]) begin
            acc_n_s[c]   = acc_r[c] + beat_ext_s;
            cnt_n_s[c]   = cnt_r[c] + CNT_W'(1);
            state_n_s[c] = ((cnt_r[c] + CNT_W'(1)) == tgt_r[c]) ? ST_DONE : ST_ACCUM;
          end else begin
            state_n_s[c] = ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (grant_s && (grant_idx_s == CH_W'(c))) begin
            state_n_s[c] = ST_IDLE;
            acc_n_s[c]   = {SUM_W{1'b0}};
            cnt_n_s[c]   = {CNT_W{1'b0}};
          end else begin
            state_n_s[c] = ST_DONE;
          end
        end
        default: begin
          state_n_s[c] = ST_IDLE;
          acc_n_s[c]   = {SUM_W{1'b0}};
          cnt_n_s[c]   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Channel state, accumulator, count and target registers.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rst) begin
        state_r[c] <= ST_IDLE;
        acc_r[c]   <= {SUM_W{1'b0}};
        cnt_r[c]   <= {CNT_W{1'b0}};
        tgt_r[c]   <= {CNT_W{1'b0}};
      end else begin
        state_r[c] <= state_n_s[c];
        acc_r[c]   <= acc_n_s[c];
        cnt_r[c]   <= cnt_n_s[c];
        tgt_r[c]   <= tgt_n_s[c];
      end
    end
  end

  // Single-entry output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_valid_r   <= 1'b0;
      sum_out_r     <= {SUM_W{1'b0}};
      sum_channel_r <= {CH_W{1'b0}};
      sum_count_r   <= {CNT_W{1'b0}};
      rr_ptr_r      <= {CH_W{1'b0}};
    end else if (grant_s) begin
      sum_valid_r   <= 1'b1;
      sum_out_r     <= acc_r[grant_idx_s];
      sum_channel_r <= grant_idx_s;
      sum_count_r   <= cnt_r[grant_idx_s];
      rr_ptr_r      <= (grant_idx_s == CH_W'(NUM_CHANNELS - 1)) ? {CH_W{1'b0}}
                                                                : grant_idx_s + CH_W'(1);
    end else if (load_en_s) begin
      sum_valid_r   <= 1'b0;
    end else begin
      sum_valid_r   <= sum_valid_r;
    end
  end

  assign bus.ready_out   = ready_s;
  assign bus.sum_valid   = sum_valid_r;
  assign bus.sum_out     = sum_out_r;
  assign bus.sum_channel = sum_channel_r;
  assign bus.sum_count   = sum_count_r;
endmodule
